// File: rtl/gmii_rx_framer_pkg.sv
// eth_rx_pkg: shared states and constants for the GMII receive framer
package eth_rx_pkg;
  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;
  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;
  localparam int          MAX_PREAMBLE  = 7;
endpackage

// File: rtl/gmii_rx_framer_if.sv
// gmii_rx_framer_if: GMII byte input and framed payload/status output bundle
interface gmii_rx_framer_if;
  logic [7:0] gmii_rxd;
  logic       gmii_dv;
  logic       gmii_er;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_first;
  logic       rx_last;
  logic       rx_bad;
  logic       frame_ok;
  logic       frame_bad;
  logic       crc_err;
  modport master (output gmii_rxd, gmii_dv, gmii_er,
                  input  rx_data, rx_valid, rx_first, rx_last, rx_bad, frame_ok, frame_bad, crc_err);
  modport slave  (input  gmii_rxd, gmii_dv, gmii_er,
                  output rx_data, rx_valid, rx_first, rx_last, rx_bad, frame_ok, frame_bad, crc_err);
endinterface

// File: rtl/gmii_rx_framer_crc32_d8.sv
// crc32_d8: combinational reflected CRC-32 update over one byte, LSB first
module crc32_d8
  import eth_rx_pkg::*;
(
  input  logic [31:0] i_crc,
  input  logic [7:0]  i_data,
  output logic [31:0] o_crc
);
  // eight serial LFSR steps unrolled into one cycle
  always_comb begin
    o_crc = i_crc;
    for (int i = 0; i < 8; i++)
      o_crc = (o_crc[0] ^ i_data[i]) ? ((o_crc >> 1) ^ CRC_POLY) : (o_crc >> 1);
  end
endmodule

// File: rtl/gmii_rx_framer.sv
// gmii_rx_framer: preamble/SFD hunt, FCS-stripping 5-byte delay line, frame checks
module gmii_rx_framer
  import eth_rx_pkg::*;
#(
  parameter int MIN_FRAME = 64,
  parameter int MAX_FRAME = 1518
) (
  input logic rgmii_rxc,
  input logic rst_n,
  gmii_rx_framer_if.slave bus
);
  localparam int CW = $clog2(MAX_FRAME + 2);
  state_t      r_state, w_state_nxt;
  logic [2:0]  r_pre_cnt;
  logic [CW-1:0] r_len;
  logic [7:0]  r_dly [5];
  logic [31:0] r_crc, w_crc_nxt;
  logic        r_er;
  logic [7:0]  r_rx_data;
  logic        r_rx_valid, r_rx_first, r_rx_last, r_rx_bad, r_frame_ok, r_frame_bad, r_crc_err;
  logic        w_push, w_end, w_over, w_full, w_valid, w_last, w_crc_bad, w_bad_end;

  crc32_d8 u_crc (.i_crc(r_crc), .i_data(bus.gmii_rxd), .o_crc(w_crc_nxt));

  // FSM state register
  always_ff @(posedge rgmii_rxc or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_state_nxt;

  // next state plus next values of the registered stream/status outputs
  always_comb begin
    w_state_nxt = r_state;
    w_push      = (r_state == DATA) && bus.gmii_dv;
    w_end       = (r_state == DATA) && !bus.gmii_dv;
    w_over      = w_push && (r_len == CW'(MAX_FRAME));
    w_full      = r_len >= CW'(5);
    w_valid     = (w_push || w_end) && w_full;
    w_last      = w_valid && (w_end || w_over);
    w_crc_bad   = r_crc != CRC_RESIDUE;
    w_bad_end   = w_crc_bad || (r_len < CW'(MIN_FRAME)) || r_er;
    case (r_state)
      IDLE:     if (bus.gmii_dv) w_state_nxt = (bus.gmii_rxd == PREAMBLE_BYTE) ? PREAMBLE : DROP;
      PREAMBLE: if (!bus.gmii_dv) w_state_nxt = IDLE;
                else if (bus.gmii_rxd == SFD_BYTE) w_state_nxt = DATA;
                else if (bus.gmii_rxd != PREAMBLE_BYTE || r_pre_cnt == 3'(MAX_PREAMBLE)) w_state_nxt = DROP;
      DATA:     if (!bus.gmii_dv) w_state_nxt = IDLE;
                else if (w_over) w_state_nxt = DROP;
      default:  if (!bus.gmii_dv) w_state_nxt = IDLE;
    endcase
  end

  // preamble count, delay line, CRC, length and registered outputs
  always_ff @(posedge rgmii_rxc or negedge rst_n)
    if (!rst_n) begin
      r_pre_cnt   <= 3'd1;
      r_len       <= '0;
      r_crc       <= CRC_INIT;
      r_er        <= 1'b0;
      for (int i = 0; i < 5; i++) r_dly[i] <= 8'h00;
      r_rx_data   <= 8'h00;
      r_rx_valid  <= 1'b0;
      r_rx_first  <= 1'b0;
      r_rx_last   <= 1'b0;
      r_rx_bad    <= 1'b0;
      r_frame_ok  <= 1'b0;
      r_frame_bad <= 1'b0;
      r_crc_err   <= 1'b0;
    end else begin
      r_pre_cnt <= (r_state == PREAMBLE && bus.gmii_dv) ? r_pre_cnt + 3'd1 : 3'd1;
      if (w_push) begin
        r_dly[0] <= bus.gmii_rxd;
        for (int i = 1; i < 5; i++) r_dly[i] <= r_dly[i-1];
        r_crc <= w_crc_nxt;
        r_len <= (r_len == CW'(MAX_FRAME + 1)) ? r_len : r_len + CW'(1);
        r_er  <= r_er | bus.gmii_er;
      end else if (r_state != DATA) begin
        r_crc <= CRC_INIT;
        r_len <= '0;
        r_er  <= 1'b0;
      end
      r_rx_data   <= w_valid ? r_dly[4] : r_rx_data;
      r_rx_valid  <= w_valid;
      r_rx_first  <= w_valid && (r_len == CW'(5));
      r_rx_last   <= w_last;
      r_rx_bad    <= w_last && (w_over || w_bad_end);
      r_frame_ok  <= w_end && w_full && !w_bad_end;
      r_frame_bad <= w_over || (w_end && (!w_full || w_bad_end));
      r_crc_err   <= w_end && w_full && w_crc_bad;
    end

  assign bus.rx_data   = r_rx_data;
  assign bus.rx_valid  = r_rx_valid;
  assign bus.rx_first  = r_rx_first;
  assign bus.rx_last   = r_rx_last;
  assign bus.rx_bad    = r_rx_bad;
  assign bus.frame_ok  = r_frame_ok;
  assign bus.frame_bad = r_frame_bad;
  assign bus.crc_err   = r_crc_err;
endmodule

// File: tb/tb_gmii_rx_framer.sv
// tb_gmii_rx_framer: table-driven frames plus preamble, oversize and reset sequences
module tb_gmii_rx_framer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #4 clk = ~clk;

  gmii_rx_framer_if bus ();
  gmii_rx_framer #(.MIN_FRAME(64), .MAX_FRAME(1518)) dut (.rgmii_rxc(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    int pre; int len; bit corrupt; int er_idx;
    int beats; int lasts; int last_bad; int ok; int bad; int crc;
  } vec_t;
  vec_t vt [8];

  int checks = 0, failures = 0, cyc = 0;
  int beats, n_first, n_last, n_lbad, n_ok, n_bad, n_crc, n_derr, idx, first_cyc, last_cyc;
  int c0, end_cyc;
  logic [7:0] fr [0:1599];

  // free-running cycle index for latency measurements
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] pay(int i);
    return 8'(i * 13 + 5);
  endfunction

  function automatic logic [31:0] crc_upd(logic [31:0] c, logic [7:0] d);
    for (int i = 0; i < 8; i++) c = (c[0] ^ d[i]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    return c;
  endfunction

  // monitor samples mid-cycle, away from the active edge
  always @(negedge clk) begin
    if (bus.rx_valid) begin
      if (bus.rx_first) begin idx = 0; n_first++; first_cyc = cyc; end
      if (bus.rx_data !== pay(idx)) n_derr++;
      idx++;
      beats++;
      if (bus.rx_last) begin n_last++; last_cyc = cyc; if (bus.rx_bad) n_lbad++; end
    end
    if (bus.frame_ok) n_ok++;
    if (bus.frame_bad) n_bad++;
    if (bus.crc_err) n_crc++;
  end

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clr();
    beats = 0; n_first = 0; n_last = 0; n_lbad = 0; n_ok = 0; n_bad = 0; n_crc = 0; n_derr = 0;
    idx = 0; first_cyc = -1; last_cyc = -1;
  endtask

  task automatic put(logic [7:0] d, logic e);
    @(posedge clk); #1;
    bus.gmii_rxd = d; bus.gmii_dv = 1'b1; bus.gmii_er = e;
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(posedge clk); #1;
      bus.gmii_rxd = 8'h00; bus.gmii_dv = 1'b0; bus.gmii_er = 1'b0;
    end
  endtask

  task automatic send(int pre, int len, bit corrupt, int er_idx);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < len; i++) fr[i] = pay(i);
    if (len >= 5) begin
      for (int i = 0; i < len - 4; i++) c = crc_upd(c, fr[i]);
      c = ~c;
      for (int k = 0; k < 4; k++) fr[len-4+k] = c[8*k +: 8];
      if (corrupt) fr[len-1] = fr[len-1] ^ 8'h01;
    end
    repeat (pre) put(8'h55, 1'b0);
    put(8'hD5, 1'b0);
    for (int i = 0; i < len; i++) begin
      put(fr[i], i == er_idx);
      if (i == 0) c0 = cyc;
    end
    idle(1);
    end_cyc = cyc;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vt[0] = '{7, 64,   1'b0, -1, 60,   1, 0, 1, 0, 0};
    vt[1] = '{7, 64,   1'b1, -1, 60,   1, 1, 0, 1, 1};
    vt[2] = '{7, 64,   1'b0, 20, 60,   1, 1, 0, 1, 0};
    vt[3] = '{7, 40,   1'b0, -1, 36,   1, 1, 0, 1, 0};
    vt[4] = '{7, 3,    1'b0, -1, 0,    0, 0, 0, 1, 0};
    vt[5] = '{1, 64,   1'b0, -1, 60,   1, 0, 1, 0, 0};
    vt[6] = '{7, 5,    1'b0, -1, 1,    1, 1, 0, 1, 0};
    vt[7] = '{7, 1518, 1'b0, -1, 1514, 1, 0, 1, 0, 0};
    bus.gmii_rxd = 8'h00; bus.gmii_dv = 1'b0; bus.gmii_er = 1'b0;
    clr();
    #20;
    chk("reset_data", int'(bus.rx_data), 0);
    chk("reset_flags", int'({bus.rx_valid, bus.rx_first, bus.rx_last, bus.rx_bad,
                              bus.frame_ok, bus.frame_bad, bus.crc_err}), 0);
    @(negedge clk) rst_n = 1'b1;
    idle(2);
    for (int v = 0; v < 8; v++) begin
      clr();
      send(vt[v].pre, vt[v].len, vt[v].corrupt, vt[v].er_idx);
      idle(3);
      chk($sformatf("v%0d_beats", v), beats, vt[v].beats);
      chk($sformatf("v%0d_first", v), n_first, vt[v].lasts);
      chk($sformatf("v%0d_last", v), n_last, vt[v].lasts);
      chk($sformatf("v%0d_last_bad", v), n_lbad, vt[v].last_bad);
      chk($sformatf("v%0d_ok", v), n_ok, vt[v].ok);
      chk($sformatf("v%0d_bad", v), n_bad, vt[v].bad);
      chk($sformatf("v%0d_crc_err", v), n_crc, vt[v].crc);
      chk($sformatf("v%0d_data", v), n_derr, 0);
      if (vt[v].beats > 0) begin
        chk($sformatf("v%0d_first_lat", v), first_cyc - c0, 6);
        chk($sformatf("v%0d_last_lat", v), last_cyc - end_cyc, 1);
      end
    end
    // broken preamble: 0x55 0x55 0x57, then SFD and a full frame
    clr();
    put(8'h55, 1'b0); put(8'h55, 1'b0); put(8'h57, 1'b0); put(8'hD5, 1'b0);
    for (int i = 0; i < 64; i++) put(pay(i), 1'b0);
    idle(3);
    chk("badpre_beats", beats, 0);
    chk("badpre_pulses", n_ok + n_bad + n_crc, 0);
    // eight preamble bytes are one too many
    clr();
    send(8, 64, 1'b0, -1);
    idle(3);
    chk("pre8_beats", beats, 0);
    chk("pre8_pulses", n_ok + n_bad + n_crc, 0);
    // oversize frame, then a good frame on the very next dv=1 cycle
    clr();
    send(7, 1600, 1'b0, -1);
    chk("over_beats", beats, 1514);
    chk("over_last_bad", n_lbad, 1);
    chk("over_last_lat", last_cyc - c0, 1519);
    chk("over_bad", n_bad, 1);
    chk("over_data", n_derr, 0);
    send(7, 64, 1'b0, -1);
    idle(3);
    chk("b2b_beats", beats, 1514 + 60);
    chk("b2b_last", n_last, 2);
    chk("b2b_ok", n_ok, 1);
    chk("b2b_bad", n_bad, 1);
    chk("b2b_last_bad", n_lbad, 1);
    // asynchronous reset in the middle of payload streaming
    clr();
    repeat (7) put(8'h55, 1'b0);
    put(8'hD5, 1'b0);
    for (int i = 0; i < 20; i++) put(pay(i), 1'b0);
    @(negedge clk);
    chk("midrst_pre_valid", int'(bus.rx_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", int'(bus.rx_valid), 0);
    chk("midrst_data", int'(bus.rx_data), 0);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 20; i < 30; i++) put(pay(i), 1'b0);
    idle(3);
    chk("midrst_last", n_last, 0);
    chk("midrst_pulses", n_ok + n_bad + n_crc, 0);
    clr();
    send(7, 64, 1'b0, -1);
    idle(3);
    chk("after_rst_ok", n_ok, 1);
    chk("after_rst_beats", beats, 60);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/gmii_rx_framer.md
# gmii_rx_framer

Receive frame controller that runs on the RGMII receive clock behind the RGMII-to-GMII DDR capture stage. It consumes the recovered GMII byte stream (data, DV, ER), locates the preamble and SFD, and emits the frame payload as a byte stream with start/last markers, FCS stripped. It checks FCS, length and PHY errors, and reports per-frame good/bad status. It is the first sequencing stage ahead of the MAC/UDP parser. The stream has no backpressure, because GMII cannot stall.

## Interface
- MIN_FRAME, 64, minimum legal frame length in bytes, destination address through FCS inclusive.
- MAX_FRAME, 1518, maximum legal frame length in bytes, same span.
- rgmii_rxc  input  1  receive clock; the block's only clock.
- rst_n  input  1  reset, asynchronous and active-low.
- gmii_rxd  input  8  GMII receive byte, already registered upstream.
- gmii_dv  input  1  GMII data valid.
- gmii_er  input  1  GMII receive error.
- rx_data  output  8  payload byte.
- rx_valid  output  1  rx_data is valid this cycle.
- rx_first  output  1  first payload byte of the frame.
- rx_last  output  1  final payload byte of the frame (the byte before the FCS).
- rx_bad  output  1  valid only with rx_last; 1 means drop the frame.
- frame_ok  output  1  one-cycle pulse for a good frame.
- frame_bad  output  1  one-cycle pulse for any bad or aborted frame after the SFD.
- crc_err  output  1  one-cycle pulse when the FCS mismatches; also sets frame_bad.

## Operation
- States:
  - IDLE: dv=1 with byte 0x55 goes to PREAMBLE; dv=1 with any other byte goes to DROP.
  - PREAMBLE: 0x55 stays, up to 7 in total; 0xD5 after at least one 0x55 goes to DATA; any other byte, or an 8th 0x55, goes to DROP; dv=0 goes to IDLE silently.
  - DATA: each byte is shifted into a 5-byte delay line, fed to the CRC, and counted. The length counter saturates at MAX_FRAME+1.
  - DROP: discards bytes until dv=0, then goes to IDLE.
- Delay line: once it holds 5 bytes, every new DATA byte pushes the oldest byte to the output. rx_first is set on the first byte pushed out of each frame.
- End of frame (first dv=0 cycle in DATA), with at least 5 bytes received:
  - The oldest delay-line byte is output with rx_last=1.
  - rx_bad = (CRC residue ≠ 0xDEBB20E3) | (length < MIN_FRAME) | ER seen in DATA.
  - Exactly one of frame_ok or frame_bad pulses. crc_err pulses when the residue mismatches.
- End of frame with fewer than 5 bytes received: no stream output; frame_bad pulses.
- Oversize: when the length reaches MAX_FRAME+1 bytes, the oldest byte is output with rx_last=1 and rx_bad=1, frame_bad pulses, and the state goes to DROP.
- CRC: IEEE 802.3, reflected (LSB-first), init 0xFFFFFFFF, no final XOR. It is run over the destination address through the FCS and checked against the residue 0xDEBB20E3.
- gmii_er in IDLE or PREAMBLE: ignored. In DROP: no effect.
- Back-to-back frames: the dv=0 end cycle returns the state to IDLE. dv=1 on the next cycle starts a new preamble.

## Timing
- Reset values: rx_data=0x00 and every other output 0. The state goes to IDLE, the delay line and counters clear, and the CRC loads 0xFFFFFFFF.
- All outputs are registered.
- Payload byte n (0-based, counted after the SFD) presented at cycle t appears on rx_data at cycle t'+1, where t' is the cycle byte n+5 arrives.
- The last byte, rx_bad, frame_ok, frame_bad and crc_err all appear at t_end+1, where t_end is the first dv=0 cycle.
- rx_valid=1 on consecutive cycles within a frame, because dv has no holes inside a frame.
- rx_first and rx_last both assert on the same byte for a 5-byte frame.
- Reset mid-frame: outputs clear asynchronously. The partial frame is lost without rx_last; downstream shares rst_n.

## Structure
- Package eth_rx_pkg holds:
  - the state enum (IDLE, PREAMBLE, DATA, DROP);
  - constants PREAMBLE_BYTE=0x55, SFD_BYTE=0xD5, CRC_POLY=0xEDB88320, CRC_INIT=0xFFFFFFFF, CRC_RESIDUE=0xDEBB20E3, MAX_PREAMBLE=7.
- Sub-module crc32_d8: combinational next-CRC for 8 data bits. It is reused by the later TX FCS generator.
- The length counter width is $clog2(MAX_FRAME+2).

## Test plan
- Good 64-byte frame (dst through FCS) after 7×0x55 and 0xD5 -> 60 rx_valid beats, first and last flagged, rx_bad=0, one frame_ok pulse; beat 0 appears 6 cycles after the first post-SFD byte.
- Same frame with the last FCS byte XORed with 0x01 -> rx_last with rx_bad=1, crc_err and frame_bad pulse, frame_ok stays 0.
- gmii_er=1 for one cycle at payload byte 20 -> 60 beats delivered, rx_bad=1, frame_bad pulse, crc_err=0 (CRC unaffected).
- Runt: 40-byte frame with valid FCS -> 36 beats, rx_bad=1, frame_bad pulse. A 3-byte frame -> no beats, frame_bad only.
- Preamble 0x55,0x55,0x57 followed by a full frame -> no beats, no pulses, IDLE after dv drops. A frame with a 1-byte preamble plus SFD is accepted.
- 1600-byte frame -> rx_last with rx_bad=1 when the 1519th byte arrives, rest discarded, one frame_bad pulse. A good 64-byte frame starting on the very next dv=1 cycle -> frame_ok.
